// File: rtl/regfile_mp_pkg.sv
// Shared definitions for the multi-port register file: clear FSM encoding
// and elaboration-time parameter legality checks.
package regfile_mp_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_e;

  localparam int MIN_REGS = 2;
  localparam int MAX_REGS = 64;
  localparam int MIN_RD   = 1;
  localparam int MAX_RD   = 4;

  function automatic bit regfile_params_ok(input int num_regs, input int addr_w, input int num_rd);
    bit ok;
    ok = (num_regs >= MIN_REGS) && (num_regs <= MAX_REGS);
    ok = ok && (addr_w >= 1) && (addr_w <= 16);
    ok = ok && ((longint'(1) << addr_w) >= longint'(num_regs));
    ok = ok && (num_rd >= MIN_RD) && (num_rd <= MAX_RD);
    return ok;
  endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Decode/writeback/debug-facing bus of the register file; the register file
// is the slave, the datapath (or bench) is the master.
interface regfile_mp_if #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int NUM_RD  = 2,
  parameter int TAP_CNT = 6
);
  logic [NUM_RD*ADDR_W-1:0]  rd_addr;
  logic [NUM_RD*DATA_W-1:0]  rd_data;
  logic                      wr_en;
  logic [ADDR_W-1:0]         wr_addr;
  logic [DATA_W-1:0]         wr_data;
  logic                      wr_ready;
  logic                      wr_err;
  logic                      clr_req;
  logic                      clr_busy;
  logic                      clr_done;
  logic [TAP_CNT*DATA_W-1:0] dbg_taps;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, clr_req,
    input  rd_data, wr_ready, wr_err, clr_busy, clr_done, dbg_taps
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, clr_req,
    output rd_data, wr_ready, wr_err, clr_busy, clr_done, dbg_taps
  );
endinterface

// File: rtl/regfile_rd_port.sv
// One combinational read port: out-of-range and hardwired-zero forcing,
// then optional same-cycle bypass of the accepted write.
module regfile_rd_port #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              wr_fire,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data
);
  logic in_range;
  logic is_zero_reg;

  assign in_range    = int'(rd_addr) < NUM_REGS;
  assign is_zero_reg = ZERO_REG && (rd_addr == '0);

  always_comb begin
    rd_data = mem_data;
    if (!in_range || is_zero_reg) begin
      rd_data = '0;
    end else if (BYPASS && wr_fire && (wr_addr == rd_addr)) begin
      rd_data = wr_data;
    end
  end
endmodule

// File: rtl/regfile_mp.sv
// Parametrised register file: NUM_RD read ports, one write port, a sequenced
// soft-clear sweep and a window of raw debug taps.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1,
  parameter int TAP_BASE = 16,
  parameter int TAP_CNT  = 6
) (
  input  logic          clk,
  input  logic          reset,
  regfile_mp_if.slave   bus
);
  // Storage covers the whole address space so any address indexes safely;
  // entries at or above NUM_REGS are held at zero and never written.
  localparam int                DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(NUM_REGS - 1);

  if (!regfile_params_ok(NUM_REGS, ADDR_W, NUM_RD)) begin : g_bad_params
    $fatal(1, "regfile_mp: illegal NUM_REGS/ADDR_W/NUM_RD combination");
  end

  clr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              wr_err_q, wr_err_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  logic wr_ready;
  logic wr_fire;
  logic wr_in_range;
  logic wr_to_zero;
  logic clr_done;

  assign wr_ready    = (state_q == ST_IDLE);
  assign wr_fire     = bus.wr_en & wr_ready;
  assign wr_in_range = int'(bus.wr_addr) < NUM_REGS;
  assign wr_to_zero  = ZERO_REG && (bus.wr_addr == '0);

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    clr_done = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.clr_req) begin
          state_d = ST_CLEAR;
          ptr_d   = '0;
        end
      end
      ST_CLEAR: begin
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == LAST_PTR) begin
          state_d  = ST_IDLE;
          clr_done = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The sweep owns the array while clearing; writes cannot fire then anyway.
  always_comb begin
    mem_d = mem_q;
    if (state_q == ST_CLEAR) begin
      mem_d[ptr_q] = '0;
    end else if (wr_fire && wr_in_range && !wr_to_zero) begin
      mem_d[bus.wr_addr] = bus.wr_data;
    end
    for (int i = NUM_REGS; i < DEPTH; i++) begin
      mem_d[i] = '0;
    end
  end

  assign wr_err_d = wr_fire & ~wr_in_range;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      wr_err_q <= 1'b0;
      mem_q    <= '{default: '0};
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      wr_err_q <= wr_err_d;
      mem_q    <= mem_d;
    end
  end

  assign bus.wr_ready = wr_ready;
  assign bus.wr_err   = wr_err_q;
  assign bus.clr_busy = (state_q == ST_CLEAR);
  assign bus.clr_done = clr_done;

  genvar gi;
  for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;

    assign addr = bus.rd_addr[gi*ADDR_W +: ADDR_W];

    regfile_rd_port #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .NUM_REGS (NUM_REGS),
      .ZERO_REG (ZERO_REG),
      .BYPASS   (BYPASS)
    ) u_rd_port (
      .rd_addr  (addr),
      .mem_data (mem_q[addr]),
      .wr_fire  (wr_fire),
      .wr_addr  (bus.wr_addr),
      .wr_data  (bus.wr_data),
      .rd_data  (data)
    );

    assign bus.rd_data[gi*DATA_W +: DATA_W] = data;
  end

  // Taps show raw storage: no zero-forcing, no bypass.
  for (gi = 0; gi < TAP_CNT; gi++) begin : g_tap
    if (TAP_BASE + gi < NUM_REGS) begin : g_live
      assign bus.dbg_taps[gi*DATA_W +: DATA_W] = mem_q[TAP_BASE + gi];
    end else begin : g_dead
      assign bus.dbg_taps[gi*DATA_W +: DATA_W] = '0;
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench: default 32x32 2-port file plus a 16-bit 8-entry 4-port file.
module tb_regfile_mp;
  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  regfile_mp_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .TAP_CNT(6)) bus_a ();
  regfile_mp_if #(.DATA_W(16), .ADDR_W(5), .NUM_RD(4), .TAP_CNT(6)) bus_b ();

  regfile_mp #(
    .DATA_W(32), .NUM_REGS(32), .ADDR_W(5), .NUM_RD(2),
    .ZERO_REG(1'b1), .BYPASS(1'b1), .TAP_BASE(16), .TAP_CNT(6)
  ) dut_a (.clk(clk), .reset(reset), .bus(bus_a));

  regfile_mp #(
    .DATA_W(16), .NUM_REGS(8), .ADDR_W(5), .NUM_RD(4),
    .ZERO_REG(1'b1), .BYPASS(1'b1), .TAP_BASE(16), .TAP_CNT(6)
  ) dut_b (.clk(clk), .reset(reset), .bus(bus_b));

  int tests = 0;
  int fails = 0;

  logic [15:0] b_vals [8] = '{16'h0000, 16'h1111, 16'h2222, 16'h3333,
                              16'h4444, 16'h5555, 16'h6666, 16'h7777};

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd_a(input logic [4:0] a0, input logic [4:0] a1);
    bus_a.rd_addr = {a1, a0};
  endtask

  task automatic set_rd_b(input logic [4:0] a0, input logic [4:0] a1,
                          input logic [4:0] a2, input logic [4:0] a3);
    bus_b.rd_addr = {a3, a2, a1, a0};
  endtask

  task automatic wr_a(input logic [4:0] a, input logic [31:0] d);
    bus_a.wr_en   = 1'b1;
    bus_a.wr_addr = a;
    bus_a.wr_data = d;
    cycle();
    bus_a.wr_en   = 1'b0;
    $display("[TB] A write r%0d = %h", a, d);
  endtask

  task automatic wr_b(input logic [4:0] a, input logic [15:0] d);
    bus_b.wr_en   = 1'b1;
    bus_b.wr_addr = a;
    bus_b.wr_data = d;
    cycle();
    bus_b.wr_en   = 1'b0;
    $display("[TB] B write r%0d = %h", a, d);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int busy_cnt;
    int done_cnt;
    int done_at;

    reset = 1'b0;
    bus_a.wr_en = 1'b0; bus_a.wr_addr = '0; bus_a.wr_data = '0;
    bus_a.clr_req = 1'b0; bus_a.rd_addr = '0;
    bus_b.wr_en = 1'b0; bus_b.wr_addr = '0; bus_b.wr_data = '0;
    bus_b.clr_req = 1'b0; bus_b.rd_addr = '0;

    repeat (2) cycle();
    chk("rst_busy", bus_a.clr_busy, 0);
    chk("rst_done", bus_a.clr_done, 0);
    chk("rst_err", bus_a.wr_err, 0);
    reset = 1'b1;
    cycle();
    chk("rst_wr_ready", bus_a.wr_ready, 1);
    chk("rst_wr_ready_b", bus_b.wr_ready, 1);

    // Everything reads zero after reset.
    for (int a = 0; a < 32; a++) begin
      set_rd_a(5'(a), 5'(31 - a));
      #1;
      chk("rst_rd0", bus_a.rd_data[31:0], 0);
      chk("rst_rd1", bus_a.rd_data[63:32], 0);
    end
    for (int j = 0; j < 6; j++) chk("rst_tap", bus_a.dbg_taps[j*32 +: 32], 0);
    $display("[TB] reset read sweep done");

    // Same-cycle bypass, then stored value and tap.
    cycle();
    bus_a.wr_en = 1'b1; bus_a.wr_addr = 5'd17; bus_a.wr_data = 32'hDEADBEEF;
    set_rd_a(5'd17, 5'd16);
    #1;
    chk("bypass_rd0", bus_a.rd_data[31:0], 32'hDEADBEEF);
    chk("bypass_other_port", bus_a.rd_data[63:32], 0);
    cycle();
    bus_a.wr_en = 1'b0;
    #1;
    $display("[TB] A write r17 = deadbeef (bypass)");
    chk("r17_stored", bus_a.rd_data[31:0], 32'hDEADBEEF);
    chk("tap1_r17", bus_a.dbg_taps[63:32], 32'hDEADBEEF);
    chk("tap0_r16", bus_a.dbg_taps[31:0], 0);

    // Hardwired zero register, including during its own write.
    bus_a.wr_en = 1'b1; bus_a.wr_addr = 5'd0; bus_a.wr_data = 32'h12345678;
    set_rd_a(5'd0, 5'd0);
    #1;
    chk("r0_bypass_blocked", bus_a.rd_data[31:0], 0);
    cycle();
    bus_a.wr_en = 1'b0;
    #1;
    $display("[TB] A write r0 = 12345678 (discarded)");
    chk("r0_reads_zero", bus_a.rd_data[31:0], 0);
    chk("r0_err_none", bus_a.wr_err, 0);

    // Narrow 4-port file: fill, independent reads, out-of-range reads.
    cycle();
    for (int i = 1; i < 8; i++) wr_b(5'(i), b_vals[i]);
    set_rd_b(5'd1, 5'd3, 5'd5, 5'd7);
    #1;
    chk("b_rd0_r1", bus_b.rd_data[15:0], 16'h1111);
    chk("b_rd1_r3", bus_b.rd_data[31:16], 16'h3333);
    chk("b_rd2_r5", bus_b.rd_data[47:32], 16'h5555);
    chk("b_rd3_r7", bus_b.rd_data[63:48], 16'h7777);
    set_rd_b(5'd2, 5'd4, 5'd6, 5'd0);
    #1;
    chk("b_rd0_r2", bus_b.rd_data[15:0], 16'h2222);
    chk("b_rd1_r4", bus_b.rd_data[31:16], 16'h4444);
    chk("b_rd2_r6", bus_b.rd_data[47:32], 16'h6666);
    chk("b_rd3_r0", bus_b.rd_data[63:48], 0);
    set_rd_b(5'd8, 5'd15, 5'd20, 5'd31);
    #1;
    chk("b_oor_8", bus_b.rd_data[15:0], 0);
    chk("b_oor_15", bus_b.rd_data[31:16], 0);
    chk("b_oor_20", bus_b.rd_data[47:32], 0);
    chk("b_oor_31", bus_b.rd_data[63:48], 0);
    for (int j = 0; j < 6; j++) chk("b_tap_oor", bus_b.dbg_taps[j*16 +: 16], 0);

    // Out-of-range write: one-cycle error pulse, no aliasing into r4.
    cycle();
    bus_b.wr_en = 1'b1; bus_b.wr_addr = 5'd20; bus_b.wr_data = 16'hBEEF;
    set_rd_b(5'd4, 5'd20, 5'd8, 5'd0);
    #1;
    chk("b_err_pre", bus_b.wr_err, 0);
    chk("b_oor_no_bypass", bus_b.rd_data[31:16], 0);
    cycle();
    bus_b.wr_en = 1'b0;
    #1;
    $display("[TB] B write r20 = beef (out of range)");
    chk("b_err_pulse", bus_b.wr_err, 1);
    chk("b_r4_intact", bus_b.rd_data[15:0], 16'h4444);
    chk("b_r20_zero", bus_b.rd_data[31:16], 0);
    cycle();
    chk("b_err_clear", bus_b.wr_err, 0);

    // Fill A with indices, then sweep.
    for (int i = 1; i < 32; i++) wr_a(5'(i), 32'(i));
    set_rd_a(5'd5, 5'd31);
    #1;
    chk("fill_r5", bus_a.rd_data[31:0], 5);
    chk("fill_r31", bus_a.rd_data[63:32], 31);
    chk("fill_tap0", bus_a.dbg_taps[31:0], 16);
    chk("fill_tap5", bus_a.dbg_taps[191:160], 21);

    cycle();
    bus_a.clr_req = 1'b1;
    busy_cnt = 0; done_cnt = 0; done_at = 0;
    for (int c = 1; c <= 40; c++) begin
      cycle();
      if (c == 1) bus_a.clr_req = 1'b0;
      if (bus_a.clr_busy) busy_cnt++;
      if (bus_a.clr_done) begin
        done_cnt++;
        done_at = busy_cnt;
      end
      if (c == 5) begin
        bus_a.wr_en = 1'b1; bus_a.wr_addr = 5'd3; bus_a.wr_data = 32'hFFFFFFFF;
        set_rd_a(5'd3, 5'd20);
        #1;
        chk("sweep_wr_ready", bus_a.wr_ready, 0);
        chk("sweep_r3_cleared", bus_a.rd_data[31:0], 0);
        chk("sweep_r20_held", bus_a.rd_data[63:32], 20);
      end
      if (c == 6) bus_a.wr_en = 1'b0;
    end
    $display("[TB] A sweep busy=%0d done_at=%0d", busy_cnt, done_at);
    chk("sweep_busy_len", busy_cnt, 32);
    chk("sweep_done_cnt", done_cnt, 1);
    chk("sweep_done_at", done_at, 32);
    chk("sweep_wr_ready_after", bus_a.wr_ready, 1);
    for (int a = 0; a < 32; a++) begin
      set_rd_a(5'(a), 5'(31 - a));
      #1;
      chk("post_sweep_rd0", bus_a.rd_data[31:0], 0);
      chk("post_sweep_rd1", bus_a.rd_data[63:32], 0);
    end
    for (int j = 0; j < 6; j++) chk("post_sweep_tap", bus_a.dbg_taps[j*32 +: 32], 0);

    // Reset at sweep cycle 10 aborts with no done pulse.
    cycle();
    wr_a(5'd10, 32'h55);
    wr_a(5'd20, 32'h66);
    wr_a(5'd30, 32'h77);
    bus_a.clr_req = 1'b1;
    done_cnt = 0;
    for (int c = 1; c <= 10; c++) begin
      cycle();
      if (c == 1) bus_a.clr_req = 1'b0;
      if (bus_a.clr_done) done_cnt++;
    end
    set_rd_a(5'd20, 5'd30);
    #1;
    chk("abort_r20_pre", bus_a.rd_data[31:0], 32'h66);
    chk("abort_busy_pre", bus_a.clr_busy, 1);
    reset = 1'b0;
    #1;
    $display("[TB] reset asserted mid-sweep");
    chk("abort_r20", bus_a.rd_data[31:0], 0);
    chk("abort_r30", bus_a.rd_data[63:32], 0);
    chk("abort_busy", bus_a.clr_busy, 0);
    chk("abort_wr_ready", bus_a.wr_ready, 1);
    chk("abort_tap4", bus_a.dbg_taps[159:128], 0);
    set_rd_a(5'd10, 5'd17);
    #1;
    chk("abort_r10", bus_a.rd_data[31:0], 0);
    chk("abort_r17", bus_a.rd_data[63:32], 0);
    for (int c = 0; c < 3; c++) begin
      cycle();
      if (bus_a.clr_done) done_cnt++;
    end
    reset = 1'b1;
    for (int c = 0; c < 30; c++) begin
      cycle();
      if (bus_a.clr_done) done_cnt++;
    end
    chk("abort_no_done", done_cnt, 0);
    chk("abort_idle", bus_a.clr_busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
